// File: rtl/demux_rr_dispatcher_pkg.sv
// Shared constants for the round-robin demux dispatcher and its arbiter helpers.
// Pure declarations: no logic, no latency, no flow control.
package demux_rr_dispatcher_pkg;
  localparam logic ST_IDLE     = 1'b0;
  localparam logic ST_SEND     = 1'b1;
  localparam int   DEMUX_MAX_N = 16;
endpackage

// File: rtl/demux_rr_dispatcher_if.sv
// Producer/consumer bundle for demux_rr_dispatcher; chan_mask exists only with DEMUX_RR_DISPATCHER_MASK_EN.
// slave = dispatcher side, master = producer plus consumers side.
interface demux_rr_dispatcher_if #(
  parameter int N = 8,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          sel_mode;
  logic [SW-1:0] sel;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] cur_sel;
  logic          busy;
`ifdef DEMUX_RR_DISPATCHER_MASK_EN
  logic [N-1:0]  chan_mask;

  modport slave (
    input  in_valid, in_data, sel_mode, sel, out_ready, chan_mask,
    output in_ready, out_valid, out_data, cur_sel, busy
  );
  modport master (
    output in_valid, in_data, sel_mode, sel, out_ready, chan_mask,
    input  in_ready, out_valid, out_data, cur_sel, busy
  );
`else
  modport slave (
    input  in_valid, in_data, sel_mode, sel, out_ready,
    output in_ready, out_valid, out_data, cur_sel, busy
  );
  modport master (
    output in_valid, in_data, sel_mode, sel, out_ready,
    input  in_ready, out_valid, out_data, cur_sel, busy
  );
`endif
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req strictly after last, wrapping modulo N.
// Zero latency; gnt_idx is only meaningful when any_req=1.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic [SW-1:0] gnt_idx,
  output logic          any_req
);
  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = '0;
    any_req = 1'b0;
    // Walk from farthest to nearest so the closest requester after last wins.
    for (int off = N; off >= 1; off--) begin
      idx = (int'(last) + off) % N;
      if (req[SW'(idx)]) begin
        gnt_idx = SW'(idx);
        any_req = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_rr_dispatcher.sv
// 1xN dispatcher holding one word; out_valid one cycle after accept, 1 word/cycle; in_ready = idle or held word leaving.
// Optional channel masking under DEMUX_RR_DISPATCHER_MASK_EN.
module demux_rr_dispatcher
  import demux_rr_dispatcher_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_rr_dispatcher_if.slave bus
);
  localparam int SW = $clog2(N);

  if (N < 2 || N > DEMUX_MAX_N) begin : g_bad_n
    $error("demux_rr_dispatcher: N out of range");
  end

  logic          state;
  logic          state_nxt;
  logic [SW-1:0] last;
  logic [SW-1:0] cur_sel_q;
  logic [W-1:0]  data_q;
  logic [SW-1:0] rr_last;
  logic [SW-1:0] rr_next;
  logic [SW-1:0] rr_gnt;
  logic [SW-1:0] sel_mod;
  logic [SW-1:0] dest;
  logic [N-1:0]  rr_req;
  logic          rr_any;
  logic          rr_block;
  logic          xfer;
  logic          accept;

  assign xfer    = (state == ST_SEND) && bus.out_ready[cur_sel_q];
  assign accept  = bus.in_valid && bus.in_ready;
  // A word accepted on the transfer edge searches from the channel just granted.
  assign rr_last = xfer ? cur_sel_q : last;
  assign rr_next = (rr_last == SW'(N - 1)) ? '0 : rr_last + SW'(1);

`ifdef DEMUX_RR_DISPATCHER_MASK_EN
  assign rr_req   = bus.out_ready & bus.chan_mask;
  assign rr_block = !bus.sel_mode && (bus.chan_mask == '0);
`else
  assign rr_req   = bus.out_ready;
  assign rr_block = 1'b0;
`endif

  rr_pick #(.N(N), .SW(SW)) u_rr_pick (
    .req     (rr_req),
    .last    (rr_last),
    .gnt_idx (rr_gnt),
    .any_req (rr_any)
  );

  always_comb begin
    sel_mod = bus.sel;
    if (int'(bus.sel) >= N) sel_mod = SW'(int'(bus.sel) - N);
  end

  always_comb begin
    dest = rr_any ? rr_gnt : rr_next;
    if (bus.sel_mode) dest = sel_mod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) begin
      if (accept) state_nxt = ST_SEND;
    end else begin
      if (xfer && !accept) state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = '0;
    bus.busy      = 1'b0;
    if (state == ST_IDLE) begin
      bus.in_ready = !rr_block;
    end else begin
      bus.in_ready  = xfer && !rr_block;
      bus.out_valid = N'(1) << cur_sel_q;
      bus.busy      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= SW'(N - 1);
      cur_sel_q <= '0;
      data_q    <= '0;
    end else begin
      if (xfer) last <= cur_sel_q;
      if (accept) begin
        data_q    <= bus.in_data;
        cur_sel_q <= dest;
      end
    end
  end

  assign bus.out_data = data_q;
  assign bus.cur_sel  = cur_sel_q;
endmodule
